// File: rtl/note_sequencer_if.sv
// Bus between the note sequencer and whoever drives it: control strobes,
// pattern RAM write port, and the oscillator-facing outputs.
// The master side issues START/STOP/LOOP and writes the pattern RAM;
// the slave side (the sequencer) drives EN/NOTE_SEL/BUSY/DONE/STEP.
interface note_sequencer_if #(
  parameter int STEPS = 8,
  parameter int DUR_W = 4
);
  localparam int AW = $clog2(STEPS);

  logic             START;
  logic             STOP;
  logic             LOOP;
  logic             WR_EN;
  logic [AW-1:0]    WR_ADDR;
  logic [DUR_W+1:0] WR_DATA;
  logic             EN;
  logic [1:0]       NOTE_SEL;
  logic             BUSY;
  logic             DONE;
  logic [AW-1:0]    STEP;

  modport master (
    output START, STOP, LOOP, WR_EN, WR_ADDR, WR_DATA,
    input  EN, NOTE_SEL, BUSY, DONE, STEP
  );

  modport slave (
    input  START, STOP, LOOP, WR_EN, WR_ADDR, WR_DATA,
    output EN, NOTE_SEL, BUSY, DONE, STEP
  );
endinterface

// File: rtl/note_sequencer.sv
// Pattern sequencer for the oscillator stage.
// Walks a small writable RAM of {note, duration} entries and drives the
// oscillator enable and 2-bit note select, one note per step. Durations are
// counted in ticks of an internal prescaler (TICK_CYC = CLK_HZ / TICK_HZ
// clock cycles per tick). A zero duration marks the end of the pattern.
// Playback is one-shot or looped (LOOP level, looked at only when the end
// of the pattern is reached), with START/STOP control and a DONE pulse.
//
// Optional build macro NOTE_GAP_EN: when defined, every note is followed by
// a silent GAP of one tick (EN low, NOTE_SEL held) before the next note,
// except when playback is about to finish to IDLE. When undefined, notes
// are separated only by the single LOAD cycle with EN held high.
module note_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int STEPS   = 8,
  parameter int DUR_W   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  note_sequencer_if.slave bus
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int AW       = $clog2(STEPS);
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int EW       = 2 + DUR_W;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [AW-1:0] LAST_STEP  = AW'(STEPS - 1);

`ifdef NOTE_GAP_EN
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

  state_t state_q, state_d;

  logic [EW-1:0]    ram [STEPS];

  logic [AW-1:0]    step_q, step_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             en_q, en_d;
  logic [1:0]       note_sel_q, note_sel_d;
  logic             busy_q;
  logic             done_q, done_d;

  logic [EW-1:0]    rd_entry;
  logic [DUR_W-1:0] rd_dur;
  logic [1:0]       rd_note;
  logic             tick;
  logic             end_of_pattern;
  logic             finish_run;

  assign rd_entry = ram[step_q];
  assign rd_dur   = rd_entry[DUR_W-1:0];
  assign rd_note  = rd_entry[EW-1:DUR_W];
  assign tick     = (presc_q == PRESC_LAST);

`ifdef NOTE_GAP_EN
  // Peek at the following entry so the gap can be skipped when the note
  // just finished is the last one of a one-shot run.
  logic [AW-1:0] next_idx;
  logic          next_is_end;

  assign next_idx    = step_q + AW'(1);
  assign next_is_end = (step_q == LAST_STEP) || (ram[next_idx][DUR_W-1:0] == '0);
`endif

  // Pattern RAM: written whenever WR_EN is high, cleared to end markers on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < STEPS; i++) begin
        ram[i] <= '0;
      end
    end else if (bus.WR_EN) begin
      ram[bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      step_q     <= '0;
      dur_q      <= '0;
      presc_q    <= '0;
      en_q       <= 1'b0;
      note_sel_q <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dur_q      <= dur_d;
      presc_q    <= presc_d;
      en_q       <= en_d;
      note_sel_q <= note_sel_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
    end
  end

  // Next-state logic; STOP is applied last so it overrides everything else.
  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    dur_d          = dur_q;
    presc_d        = presc_q;
    en_d           = en_q;
    note_sel_d     = note_sel_q;
    done_d         = 1'b0;
    end_of_pattern = 1'b0;
    finish_run     = 1'b0;

    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (bus.START) begin
          state_d = LOAD;
          step_d  = '0;
        end
      end

      LOAD: begin
        if (rd_dur != '0) begin
          note_sel_d = rd_note;
          dur_d      = rd_dur;
          presc_d    = '0;
          en_d       = 1'b1;
          state_d    = PLAY;
        end else if (step_q == '0) begin
          finish_run = 1'b1;
        end else begin
          end_of_pattern = 1'b1;
        end
      end

      PLAY: begin
        en_d    = 1'b1;
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
`ifdef NOTE_GAP_EN
            if ((step_q == LAST_STEP) && !bus.LOOP) begin
              finish_run = 1'b1;
            end else if (next_is_end && !bus.LOOP) begin
              step_d  = step_q + AW'(1);
              state_d = LOAD;
            end else begin
              presc_d = '0;
              en_d    = 1'b0;
              state_d = GAP;
            end
`else
            if (step_q == LAST_STEP) begin
              end_of_pattern = 1'b1;
            end else begin
              step_d  = step_q + AW'(1);
              state_d = LOAD;
            end
`endif
          end
        end
      end

`ifdef NOTE_GAP_EN
      GAP: begin
        en_d    = 1'b0;
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          step_d  = step_q + AW'(1);
          state_d = LOAD;
        end
      end
`endif

      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (end_of_pattern) begin
      if (bus.LOOP) begin
        step_d  = '0;
        state_d = LOAD;
      end else begin
        finish_run = 1'b1;
      end
    end

    if (finish_run) begin
      state_d = IDLE;
      en_d    = 1'b0;
      done_d  = 1'b1;
    end

    if (bus.STOP) begin
      state_d    = IDLE;
      step_d     = step_q;
      note_sel_d = note_sel_q;
      en_d       = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign bus.EN       = en_q;
  assign bus.NOTE_SEL = note_sel_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.STEP     = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a 4-cycle tick.
// Expected output vectors {EN, NOTE_SEL, BUSY, DONE, STEP} are pushed into a
// queue from a note-level description of each run, then popped and compared
// one per clock against the DUT.
module tb_note_sequencer;

  logic CLK;
  logic RST;

  note_sequencer_if #(.STEPS(8), .DUR_W(4)) sb ();

  note_sequencer #(
    .CLK_HZ (50_000_000),
    .TICK_HZ(12_500_000),
    .STEPS  (8),
    .DUR_W  (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(sb)
  );

  int checks_done = 0;
  int errors      = 0;

  logic [7:0] expq [$];
  logic [7:0] last_exp;
  int         exp_limit;
  logic [5:0] pat_a [8];
  logic [5:0] pat_b [8];

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard bound on total run time.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks_done++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got en=%b note=%0d busy=%b done=%b step=%0d, expected en=%b note=%0d busy=%b done=%b step=%0d",
               tag, observed[7], observed[6:5], observed[4], observed[3], observed[2:0],
               expected[7], expected[6:5], expected[4], expected[3], expected[2:0]);
    end
  endtask

  function automatic logic [7:0] observedVec();
    return {sb.EN, sb.NOTE_SEL, sb.BUSY, sb.DONE, sb.STEP};
  endfunction

  task automatic pushExp(input logic en, input logic [1:0] note, input logic busy,
                         input logic done, input logic [2:0] step);
    if (expq.size() < exp_limit) begin
      expq.push_back({en, note, busy, done, step});
      last_exp = {en, note, busy, done, step};
    end
  endtask

  task automatic compareNow(input string tag);
    logic [7:0] e;
    if (expq.size() == 0) begin
      checkOutput({tag, " (no expectation queued)"}, observedVec(), ~observedVec());
    end else begin
      e = expq.pop_front();
      checkOutput(tag, observedVec(), e);
    end
  endtask

  // Note-level model: one LOAD cycle per step, dur*4 PLAY cycles per note,
  // optional 4-cycle gap, end marker handling, looping for loop_wraps wraps.
  task automatic buildExpected(input int loop_wraps, input int mark_pass,
                               input int mark_step, output int mark_idx);
    int s = 0;
    int pass = 0;
    int wraps = 0;
    int d;
    bit fin = 0;
    bit loop_now;
    logic en_cur = 1'b0;
    logic [1:0] note;
    logic [5:0] ent;
`ifdef NOTE_GAP_EN
    logic [5:0] ent_next;
    bit next_end;
`endif
    note = last_exp[6:5];
    mark_idx = -1;
    while (!fin && expq.size() < exp_limit) begin
      ent = (pass == 0) ? pat_a[s] : pat_b[s];
      d = int'(ent[3:0]);
      if (pass == mark_pass && s == mark_step && mark_idx < 0) mark_idx = expq.size();
      pushExp(en_cur, note, 1'b1, 1'b0, s[2:0]);
      loop_now = (wraps < loop_wraps);
      if (d == 0) begin
        if (s == 0 || !loop_now) begin
          pushExp(1'b0, note, 1'b0, 1'b1, s[2:0]);
          fin = 1;
        end else begin
          wraps++; pass++; s = 0;
        end
      end else begin
        note = ent[5:4];
        en_cur = 1'b1;
        repeat (d * 4) pushExp(1'b1, note, 1'b1, 1'b0, s[2:0]);
        if (s == 7 && !loop_now) begin
          pushExp(1'b0, note, 1'b0, 1'b1, s[2:0]);
          fin = 1;
        end else begin
`ifdef NOTE_GAP_EN
          if (s == 7) begin
            next_end = 1;
          end else begin
            ent_next = (pass == 0) ? pat_a[s+1] : pat_b[s+1];
            next_end = (ent_next[3:0] == 4'd0);
          end
          if (!(next_end && !loop_now)) begin
            en_cur = 1'b0;
            repeat (4) pushExp(1'b0, note, 1'b1, 1'b0, s[2:0]);
          end
`endif
          if (s == 7) begin
            wraps++; pass++; s = 0;
          end else begin
            s++;
          end
        end
      end
    end
    if (fin) pushExp(1'b0, note, 1'b0, 1'b0, s[2:0]);
  endtask

  // Cut the expected run at the cycle a STOP lands and append the idle result.
  task automatic truncateForStop(input int stop_at);
    logic [7:0] held;
    expq = expq[0:stop_at-1];
    held = expq[$];
    exp_limit = 100000;
    pushExp(1'b0, held[6:5], 1'b0, 1'b0, held[2:0]);
    pushExp(1'b0, held[6:5], 1'b0, 1'b0, held[2:0]);
  endtask

  task automatic writeAll();
    for (int i = 0; i < 8; i++) begin
      sb.WR_EN   = 1'b1;
      sb.WR_ADDR = i[2:0];
      sb.WR_DATA = pat_a[i];
      @(posedge CLK); #1;
    end
    sb.WR_EN = 1'b0;
  endtask

  // Drive one run (START on the first edge) and compare every queued cycle.
  task automatic applyStimulus(input string tag, input logic loop_init, input int loop_drop_at,
                               input int wr_at, input logic [2:0] wr_addr, input logic [5:0] wr_data,
                               input int stop_at, input int restart_at);
    int total;
    total = expq.size();
    sb.LOOP = loop_init;
    for (int i = 0; i < total; i++) begin
      sb.START   = (i == 0) || (i == restart_at);
      sb.STOP    = (i == stop_at);
      if (i == loop_drop_at) sb.LOOP = 1'b0;
      sb.WR_EN   = (i == wr_at);
      sb.WR_ADDR = wr_addr;
      sb.WR_DATA = wr_data;
      @(posedge CLK); #1;
      sb.START = 1'b0;
      sb.STOP  = 1'b0;
      sb.WR_EN = 1'b0;
      compareNow($sformatf("%s[%0d]", tag, i));
    end
    sb.LOOP = 1'b0;
  endtask

  initial begin
    int m;
    RST        = 1'b1;
    sb.START   = 1'b0;
    sb.STOP    = 1'b0;
    sb.LOOP    = 1'b0;
    sb.WR_EN   = 1'b0;
    sb.WR_ADDR = '0;
    sb.WR_DATA = '0;
    last_exp   = 8'h00;
    exp_limit  = 100000;

    // Reset values while RST is held.
    repeat (2) @(posedge CLK);
    #1;
    pushExp(1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
    compareNow("reset_values");
    #4 RST = 1'b0;
    @(posedge CLK); #1;

    // Start a two-note run, then assert RST asynchronously mid-PLAY.
    for (int i = 0; i < 8; i++) pat_a[i] = 6'd0;
    pat_a[0] = {2'd1, 4'd2};
    pat_a[1] = {2'd3, 4'd1};
    pat_b = pat_a;
    writeAll();
    exp_limit = 5;
    buildExpected(0, -1, -1, m);
    applyStimulus("pre_reset", 1'b0, -1, -1, 3'd0, 6'd0, -1, -1);
    #2 RST = 1'b1;
    #1;
    exp_limit = 100000;
    pushExp(1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
    compareNow("async_reset");
    #2 RST = 1'b0;
    last_exp = 8'h00;
    @(posedge CLK); #1;

    // RAM was cleared by reset: START sees an empty pattern.
    for (int i = 0; i < 8; i++) pat_a[i] = 6'd0;
    pat_b = pat_a;
    buildExpected(0, -1, -1, m);
    applyStimulus("empty", 1'b0, -1, -1, 3'd0, 6'd0, -1, -1);

    // Two notes, one-shot, with a second START while busy that must be ignored.
    pat_a[0] = {2'd1, 4'd2};
    pat_a[1] = {2'd3, 4'd1};
    pat_b = pat_a;
    writeAll();
    buildExpected(0, -1, -1, m);
    applyStimulus("two_notes", 1'b0, -1, -1, 3'd0, 6'd0, -1, 5);

    // STOP during the second note: EN drops, no DONE, STEP retained.
    buildExpected(0, 0, 1, m);
    truncateForStop(m + 2);
    applyStimulus("stop_play", 1'b0, -1, -1, 3'd0, 6'd0, m + 2, -1);

    // START and STOP together from IDLE: nothing happens.
    pushExp(1'b0, last_exp[6:5], 1'b0, 1'b0, last_exp[2:0]);
    pushExp(1'b0, last_exp[6:5], 1'b0, 1'b0, last_exp[2:0]);
    applyStimulus("start_stop", 1'b0, -1, -1, 3'd0, 6'd0, 0, -1);

    // Eight one-tick notes looped once; LOOP dropped during step 3 of pass 2.
    for (int i = 0; i < 8; i++) pat_a[i] = {i[1:0], 4'd1};
    pat_b = pat_a;
    writeAll();
    buildExpected(1, 1, 3, m);
    applyStimulus("loop8", 1'b1, m + 2, -1, 3'd0, 6'd0, -1, -1);

    // Rewrite entry 0 while it plays: the change only shows on the next pass.
    for (int i = 0; i < 8; i++) pat_a[i] = 6'd0;
    pat_a[0] = {2'd1, 4'd2};
    pat_a[1] = {2'd3, 4'd1};
    writeAll();
    pat_b = pat_a;
    pat_b[0] = {2'd2, 4'd3};
    buildExpected(100, 1, 1, m);
    truncateForStop(m + 2);
    applyStimulus("live_write", 1'b1, -1, 3, 3'd0, pat_b[0], m + 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks_done, errors);
    $finish;
  end

endmodule
